// File: rtl/tx_route_stage_if.sv
// Flit bus of the transmit stage: FIFO head, routing-table lookup and per-direction output strobes.
// master = the stage; slave = the surrounding FIFO, table and output ports.
interface tx_route_stage_if #(
  parameter int PAYLOAD_SIZE = 8,
  parameter int ADDR_BITS    = 4,
  parameter int NUM_DIRS     = 5,
  parameter int BITS_DIR     = 3
);
  logic                              empty;
  logic [PAYLOAD_SIZE+ADDR_BITS-1:0] item_in;
  logic                              read;
  logic [ADDR_BITS-1:0]              table_addr;
  logic [BITS_DIR-1:0]               table_data;
  logic [PAYLOAD_SIZE+ADDR_BITS-1:0] item_out;
  logic [NUM_DIRS-1:0]               out_ena;
  logic [NUM_DIRS-1:0]               out_busy;

  modport master (
    input  empty, item_in, table_data, out_busy,
    output read, table_addr, item_out, out_ena
  );

  modport slave (
    output empty, item_in, table_data, out_busy,
    input  read, table_addr, item_out, out_ena
  );
endinterface

// File: rtl/tx_route_stage.sv
// Router transmit stage: pop flit, registered direction lookup, one-hot send; 2-cycle pop-to-send latency.
// Holds the flit while the chosen output is busy; after TIMEOUT stall cycles flags stall and optionally drops.
module tx_route_stage #(
  parameter int PAYLOAD_SIZE    = 8,
  parameter int ADDR_BITS       = 4,
  parameter int NUM_DIRS        = 5,
  parameter int BITS_DIR        = 3,
  parameter int TIMEOUT         = 16,
  parameter int DROP_ON_TIMEOUT = 0,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  tx_route_stage_if.master bus,
  output logic             stalled,
  output logic             drop,
  output logic [CNT_W-1:0] sent_cnt,
  output logic [CNT_W-1:0] drop_cnt
);
  localparam int FW = PAYLOAD_SIZE + ADDR_BITS;
  localparam int SW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [SW-1:0]     STALL_MAX = SW'(TIMEOUT - 1);
  localparam logic [BITS_DIR:0] DIR_LIMIT = (BITS_DIR + 1)'(NUM_DIRS);

  typedef enum logic [1:0] {IDLE, LOOKUP, SEND} state_t;

  state_t              state, state_nxt;
  logic [FW-1:0]       hold;
  logic [BITS_DIR-1:0] dir_reg;
  logic [SW-1:0]       stall_cnt;
  logic [NUM_DIRS-1:0] ena;
  logic                sel_busy, xfer, bad_dir, timeout_drop, rd;

  // Only the selected direction's busy bit matters; the others are ignored.
  always_comb begin
    sel_busy = 1'b0;
    ena      = '0;
    for (int d = 0; d < NUM_DIRS; d++) begin
      if (dir_reg == BITS_DIR'(d)) begin
        sel_busy = bus.out_busy[d];
        ena[d]   = (state == SEND) && !bus.out_busy[d];
      end
    end
  end

  assign xfer         = |ena;
  assign stalled      = (state == SEND) && (stall_cnt == STALL_MAX);
  assign bad_dir      = (state == LOOKUP) && ({1'b0, bus.table_data} >= DIR_LIMIT);
  assign timeout_drop = (DROP_ON_TIMEOUT != 0) && stalled && sel_busy;
  assign drop         = bad_dir || timeout_drop;

  assign bus.out_ena    = ena;
  assign bus.item_out   = hold;
  assign bus.table_addr = hold[ADDR_BITS-1:0];
  assign bus.read       = rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rd        = 1'b0;
    case (state)
      IDLE: begin
        rd = !bus.empty;
        if (rd) state_nxt = LOOKUP;
      end
      LOOKUP: begin
        state_nxt = bad_dir ? IDLE : SEND;
      end
      SEND: begin
        // A completed transfer may pop the next flit in the same cycle.
        if (xfer) begin
          rd        = !bus.empty;
          state_nxt = rd ? LOOKUP : IDLE;
        end else if (timeout_drop) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold      <= '0;
      dir_reg   <= '0;
      stall_cnt <= '0;
      sent_cnt  <= '0;
      drop_cnt  <= '0;
    end else begin
      if (rd) begin
        hold      <= bus.item_in;
        stall_cnt <= '0;
      end else if ((state == SEND) && sel_busy && (stall_cnt != STALL_MAX)) begin
        stall_cnt <= stall_cnt + SW'(1);
      end
      if ((state == LOOKUP) && !bad_dir) begin
        dir_reg <= bus.table_data;
      end
      if (xfer && (sent_cnt != '1)) begin
        sent_cnt <= sent_cnt + CNT_W'(1);
      end
      if (drop && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_tx_route_stage.sv
// Bench for tx_route_stage: default instance driven from a FIFO model with a scoreboard,
// plus two TIMEOUT=4 instances (drop / hold) used for stall, timeout and counter saturation.
module tb_tx_route_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int n_chk = 0;
  int n_fail = 0;

  tx_route_stage_if #(.PAYLOAD_SIZE(8), .ADDR_BITS(4), .NUM_DIRS(5), .BITS_DIR(3)) i0 ();
  tx_route_stage_if #(.PAYLOAD_SIZE(8), .ADDR_BITS(4), .NUM_DIRS(5), .BITS_DIR(3)) i1 ();
  tx_route_stage_if #(.PAYLOAD_SIZE(8), .ADDR_BITS(4), .NUM_DIRS(5), .BITS_DIR(3)) i2 ();

  logic        stalled0, drop0, stalled1, drop1, stalled2, drop2;
  logic [15:0] sent0, dcnt0, sent2, dcnt2;
  logic [1:0]  sent1, dcnt1;

  tx_route_stage u0 (
    .clk(clk), .rst_n(rst_n), .bus(i0.master), .stalled(stalled0), .drop(drop0),
    .sent_cnt(sent0), .drop_cnt(dcnt0)
  );
  tx_route_stage #(.TIMEOUT(4), .DROP_ON_TIMEOUT(1), .CNT_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(i1.master), .stalled(stalled1), .drop(drop1),
    .sent_cnt(sent1), .drop_cnt(dcnt1)
  );
  tx_route_stage #(.TIMEOUT(4), .DROP_ON_TIMEOUT(0)) u2 (
    .clk(clk), .rst_n(rst_n), .bus(i2.master), .stalled(stalled2), .drop(drop2),
    .sent_cnt(sent2), .drop_cnt(dcnt2)
  );

  logic [2:0] tbl [16];
  logic [2:0] dir1;
  assign i0.table_data = tbl[i0.table_addr];
  assign i1.table_data = dir1;
  assign i2.table_data = 3'd3;

  typedef struct {
    logic [11:0] flit;
    logic [4:0]  ena;
    logic        is_drop;
  } exp_t;

  exp_t        exp_q[$];
  logic [11:0] fifo_q[$];
  logic        pop_pending = 1'b0;

  function automatic void refresh();
    i0.empty   = (fifo_q.size() == 0);
    i0.item_in = (fifo_q.size() == 0) ? 12'h000 : fifo_q[0];
  endfunction

  task automatic push_flit(input logic [11:0] f);
    exp_t       e;
    logic [2:0] d;
    d         = tbl[f[3:0]];
    e.flit    = f;
    e.is_drop = (d >= 3'd5);
    e.ena     = e.is_drop ? 5'b00000 : (5'b00001 << d);
    exp_q.push_back(e);
    fifo_q.push_back(f);
    refresh();
  endtask

  // Show-ahead FIFO model: a pop seen at the negedge retires the head after the next edge.
  always @(negedge clk) pop_pending = i0.read;
  always @(posedge clk) begin
    #1;
    if (pop_pending && fifo_q.size() > 0) begin
      void'(fifo_q.pop_front());
      refresh();
    end
  end

  always @(negedge clk) begin : scoreboard
    exp_t e;
    if (rst_n === 1'b1 && (i0.out_ena !== 5'b00000 || drop0 === 1'b1)) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: out_ena=%b drop=%b item_out=%h, required no activity", i0.out_ena, drop0, i0.item_out);
      end else begin
        e = exp_q.pop_front();
        if (i0.item_out !== e.flit || i0.out_ena !== e.ena || drop0 !== e.is_drop) begin
          n_fail++;
          $display("FAIL sb_flit: item_out=%h out_ena=%b drop=%b, required %h %b %b",
                   i0.item_out, i0.out_ena, drop0, e.flit, e.ena, e.is_drop);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_chk++; if (i0.out_ena !== 5'b0)   begin n_fail++; $display("FAIL rst_out_ena: got %b, required 00000", i0.out_ena); end
    n_chk++; if (i0.read !== 1'b0)      begin n_fail++; $display("FAIL rst_read: got %b, required 0", i0.read); end
    n_chk++; if (i0.item_out !== 12'h0) begin n_fail++; $display("FAIL rst_item_out: got %h, required 000", i0.item_out); end
    n_chk++; if (stalled0 !== 1'b0)     begin n_fail++; $display("FAIL rst_stalled: got %b, required 0", stalled0); end
    n_chk++; if (drop0 !== 1'b0)        begin n_fail++; $display("FAIL rst_drop: got %b, required 0", drop0); end
    n_chk++; if (sent0 !== 16'd0 || dcnt0 !== 16'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d/%0d, required 0/0", sent0, dcnt0); end
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    n_chk++; if (i0.read !== 1'b0) begin n_fail++; $display("FAIL idle_empty_read: got %b, required 0", i0.read); end
  endtask

  task automatic test_basic();
    @(posedge clk); #1;
    tbl[3] = 3'd2;
    push_flit(12'hA53);
    @(negedge clk);
    n_chk++; if (i0.read !== 1'b1) begin n_fail++; $display("FAIL basic_read_c0: got %b, required 1", i0.read); end
    @(negedge clk);
    n_chk++; if (i0.read !== 1'b0 || i0.out_ena !== 5'b0) begin n_fail++; $display("FAIL basic_lookup_c1: read=%b out_ena=%b, required 0 00000", i0.read, i0.out_ena); end
    @(negedge clk);
    n_chk++; if (i0.out_ena !== 5'b00100 || i0.item_out !== 12'hA53) begin n_fail++; $display("FAIL basic_send_c2: out_ena=%b item=%h, required 00100 a53", i0.out_ena, i0.item_out); end
    @(negedge clk);
    n_chk++; if (i0.out_ena !== 5'b0 || i0.read !== 1'b0 || sent0 !== 16'd1) begin n_fail++; $display("FAIL basic_after_c3: out_ena=%b read=%b sent=%0d, required 00000 0 1", i0.out_ena, i0.read, sent0); end
  endtask

  task automatic test_busy_stall();
    @(posedge clk); #1;
    tbl[5] = 3'd1;
    i0.out_busy = 5'b00010;
    push_flit(12'h3C5);
    @(negedge clk);
    n_chk++; if (i0.read !== 1'b1) begin n_fail++; $display("FAIL stall_read_c0: got %b, required 1", i0.read); end
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_chk++; if (i0.out_ena !== 5'b0 || stalled0 !== 1'b0) begin n_fail++; $display("FAIL stall_hold_%0d: out_ena=%b stalled=%b, required 00000 0", k, i0.out_ena, stalled0); end
    end
    // Other directions stay busy: only the selected busy bit may gate the send.
    @(posedge clk); #1; i0.out_busy = 5'b11101;
    @(negedge clk);
    n_chk++; if (i0.out_ena !== 5'b00010) begin n_fail++; $display("FAIL stall_release: got %b, required 00010", i0.out_ena); end
    @(posedge clk); #1; i0.out_busy = 5'b0;
    @(negedge clk);
    n_chk++; if (sent0 !== 16'd2) begin n_fail++; $display("FAIL stall_sent: got %0d, required 2", sent0); end
  endtask

  task automatic test_back_to_back();
    logic exp_rd, exp_en;
    @(posedge clk); #1;
    tbl[0] = 3'd0; tbl[1] = 3'd4; tbl[2] = 3'd3;
    push_flit(12'h010); push_flit(12'h021); push_flit(12'h032); push_flit(12'h043);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      exp_rd = (c % 2 == 0) && (c <= 6);
      exp_en = (c % 2 == 0) && (c >= 2) && (c <= 8);
      n_chk++; if (i0.read !== exp_rd || (i0.out_ena !== 5'b0) !== exp_en) begin n_fail++; $display("FAIL b2b_c%0d: read=%b out_ena=%b, required read=%b ena_active=%b", c, i0.read, i0.out_ena, exp_rd, exp_en); end
    end
    n_chk++; if (sent0 !== 16'd6) begin n_fail++; $display("FAIL b2b_sent: got %0d, required 6", sent0); end
  endtask

  task automatic test_invalid_dir();
    @(posedge clk); #1;
    tbl[7] = 3'd7;
    push_flit(12'h5A7); push_flit(12'h0F3);
    @(negedge clk);
    @(negedge clk);
    n_chk++; if (drop0 !== 1'b1 || i0.out_ena !== 5'b0 || i0.read !== 1'b0) begin n_fail++; $display("FAIL inv_lookup: drop=%b out_ena=%b read=%b, required 1 00000 0", drop0, i0.out_ena, i0.read); end
    @(negedge clk);
    n_chk++; if (drop0 !== 1'b0 || i0.read !== 1'b1 || dcnt0 !== 16'd1) begin n_fail++; $display("FAIL inv_next_pop: drop=%b read=%b drop_cnt=%0d, required 0 1 1", drop0, i0.read, dcnt0); end
    repeat (3) @(negedge clk);
    n_chk++; if (sent0 !== 16'd7) begin n_fail++; $display("FAIL inv_sent: got %0d, required 7", sent0); end
  endtask

  task automatic test_timeout();
    @(posedge clk); #1;
    dir1 = 3'd3;
    i1.item_in = 12'h113; i1.empty = 1'b0; i1.out_busy = 5'b01000;
    i2.item_in = 12'h223; i2.empty = 1'b0; i2.out_busy = 5'b01000;
    @(negedge clk);
    n_chk++; if (i1.read !== 1'b1 || i2.read !== 1'b1) begin n_fail++; $display("FAIL to_read: got %b/%b, required 1/1", i1.read, i2.read); end
    @(posedge clk); #1; i1.empty = 1'b1; i2.empty = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_chk++; if (stalled1 !== (k == 4) || drop1 !== (k == 4) || i1.out_ena !== 5'b0) begin n_fail++; $display("FAIL to_drop_send%0d: stalled=%b drop=%b out_ena=%b, required %b %b 00000", k, stalled1, drop1, i1.out_ena, k == 4, k == 4); end
      n_chk++; if (stalled2 !== (k == 4)) begin n_fail++; $display("FAIL to_hold_send%0d: stalled=%b, required %b", k, stalled2, k == 4); end
    end
    @(negedge clk);
    n_chk++; if (drop1 !== 1'b0 || dcnt1 !== 2'd1 || i1.read !== 1'b0 || stalled1 !== 1'b0) begin n_fail++; $display("FAIL to_drop_idle: drop=%b drop_cnt=%0d read=%b stalled=%b, required 0 1 0 0", drop1, dcnt1, i1.read, stalled1); end
    n_chk++; if (stalled2 !== 1'b1 || i2.out_ena !== 5'b0 || drop2 !== 1'b0) begin n_fail++; $display("FAIL to_hold_wait: stalled=%b out_ena=%b drop=%b, required 1 00000 0", stalled2, i2.out_ena, drop2); end
    @(posedge clk); #1; i2.out_busy = 5'b0;
    @(negedge clk);
    n_chk++; if (i2.out_ena !== 5'b01000 || i2.item_out !== 12'h223) begin n_fail++; $display("FAIL to_hold_deliver: out_ena=%b item=%h, required 01000 223", i2.out_ena, i2.item_out); end
    @(negedge clk);
    n_chk++; if (sent2 !== 16'd1 || stalled2 !== 1'b0 || dcnt2 !== 16'd0) begin n_fail++; $display("FAIL to_hold_after: sent=%0d stalled=%b drop_cnt=%0d, required 1 0 0", sent2, stalled2, dcnt2); end
  endtask

  task automatic test_saturation();
    @(posedge clk); #1;
    i1.out_busy = 5'b0; dir1 = 3'd0; i1.empty = 1'b0;
    repeat (12) @(negedge clk);
    @(posedge clk); #1; i1.empty = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++; if (sent1 !== 2'd3) begin n_fail++; $display("FAIL sat_sent: got %0d, required 3", sent1); end
    @(posedge clk); #1; dir1 = 3'd6; i1.empty = 1'b0;
    repeat (10) @(negedge clk);
    @(posedge clk); #1; i1.empty = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++; if (dcnt1 !== 2'd3 || sent1 !== 2'd3) begin n_fail++; $display("FAIL sat_drop: drop_cnt=%0d sent=%0d, required 3 3", dcnt1, sent1); end
  endtask

  task automatic test_reset_mid_send();
    n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL sb_drained: %0d flits outstanding, required 0", exp_q.size()); end
    @(posedge clk); #1;
    tbl[9] = 3'd4;
    i0.out_busy = 5'b10000;
    push_flit(12'h7E9);
    repeat (3) @(negedge clk);
    n_chk++; if (i0.out_ena !== 5'b0 || i0.read !== 1'b0) begin n_fail++; $display("FAIL mid_busy: out_ena=%b read=%b, required 00000 0", i0.out_ena, i0.read); end
    #2; rst_n = 1'b0;
    #1;
    n_chk++; if (i0.out_ena !== 5'b0 || i0.read !== 1'b0 || i0.item_out !== 12'h0) begin n_fail++; $display("FAIL mid_rst_outs: out_ena=%b read=%b item=%h, required 00000 0 000", i0.out_ena, i0.read, i0.item_out); end
    n_chk++; if (sent0 !== 16'd0 || dcnt0 !== 16'd0) begin n_fail++; $display("FAIL mid_rst_cnt: got %0d/%0d, required 0/0", sent0, dcnt0); end
    exp_q.delete();
    fifo_q.delete();
    refresh();
    i0.out_busy = 5'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_chk++; if (i0.out_ena !== 5'b0 || i0.read !== 1'b0 || sent0 !== 16'd0) begin n_fail++; $display("FAIL mid_post_c%0d: out_ena=%b read=%b sent=%0d, required 00000 0 0", c, i0.out_ena, i0.read, sent0); end
    end
  endtask

  initial begin
    for (int a = 0; a < 16; a++) tbl[a] = 3'd0;
    dir1 = 3'd3;
    i0.out_busy = 5'b0; refresh();
    i1.empty = 1'b1; i1.item_in = 12'h0; i1.out_busy = 5'b0;
    i2.empty = 1'b1; i2.item_in = 12'h0; i2.out_busy = 5'b0;
    test_reset();
    test_basic();
    test_busy_stall();
    test_back_to_back();
    test_invalid_dir();
    test_timeout();
    test_saturation();
    test_reset_mid_send();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/tx_route_stage.md
Name: tx_route_stage

Overview:
Parametrised next-generation transmit stage for a router input port. Pops flits from the input FIFO head and registers each flit plus its routing-table direction. Presents the flit on the one-hot enable of the selected output direction until that output is not busy. Adds N-direction generality, a registered lookup, stall/timeout handling with optional drop, and saturating statistics.

Parameters:
PAYLOAD_SIZE, 8, payload bits per flit
ADDR_BITS, 4, destination address bits, located in the flit LSBs
NUM_DIRS, 5, number of output directions; direction code d selects out_ena[d]
BITS_DIR, 3, routing-table direction code width; must satisfy 2^BITS_DIR >= NUM_DIRS
TIMEOUT, 16, number of SEND stall cycles before the stall is declared (>=2)
DROP_ON_TIMEOUT, 0, 1 = discard the flit when the stall is declared; 0 = hold it indefinitely
CNT_W, 16, statistics counter width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
empty  input  1  input FIFO empty; item_in is valid when low (show-ahead FIFO)
item_in  input  PAYLOAD_SIZE+ADDR_BITS  FIFO head flit
read  output  1  FIFO pop; the flit is captured on the same edge
table_addr  output  ADDR_BITS  routing-table address, taken from the held flit's ADDR_BITS LSBs
table_data  input  BITS_DIR  routing-table direction, combinational from table_addr
item_out  output  PAYLOAD_SIZE+ADDR_BITS  held flit, registered
out_ena  output  NUM_DIRS  one-hot transfer strobe per direction
out_busy  input  NUM_DIRS  per-direction busy
stalled  output  1  high while a stall has been declared on the current flit
drop  output  1  single-cycle pulse when a flit is discarded
sent_cnt  output  CNT_W  flits delivered, saturating
drop_cnt  output  CNT_W  flits discarded, saturating

Behaviour:
- Reset (async, rst_n low): state = IDLE; hold register, dir_reg, stall_cnt, sent_cnt and drop_cnt = 0.
- Reset outputs: read = 0, out_ena = 0, item_out = 0, stalled = 0, drop = 0.
- A reset asserted mid-operation discards the held flit. No out_ena pulse is issued for it and the counters do not change.
- Three states: IDLE, LOOKUP, SEND. item_out always shows the hold register. table_addr = hold[ADDR_BITS-1:0].
- IDLE:
  - read = !empty.
  - When read = 1: capture item_in into the hold register, clear stall_cnt, move to LOOKUP.
- LOOKUP (exactly one cycle):
  - If table_data >= NUM_DIRS: drop = 1 this cycle, drop_cnt increments, move to IDLE.
  - Otherwise: dir_reg <= table_data, move to SEND.
- SEND:
  - out_ena[dir_reg] = !out_busy[dir_reg]; all other out_ena bits are 0. out_ena is combinational from out_busy.
  - Transfer completes in any cycle where out_ena is nonzero; sent_cnt increments on that edge.
  - On transfer: read = !empty in the same cycle. If read = 1, capture the next flit and move to LOOKUP; otherwise move to IDLE.
  - Throughput is one flit per 2 cycles. Latency from pop to the earliest out_ena is 2 cycles (pop edge, LOOKUP cycle, then SEND).
  - When out_busy[dir_reg] = 1: stall_cnt increments, saturating at TIMEOUT-1.
  - stalled = (state == SEND) & (stall_cnt == TIMEOUT-1).
  - If stalled & out_busy[dir_reg] & DROP_ON_TIMEOUT: drop = 1 this cycle, drop_cnt increments, move to IDLE, no read this cycle.
  - If DROP_ON_TIMEOUT = 0: remain in SEND with stalled held high until the output frees, then transfer normally.
  - Busy bits of non-selected directions are ignored.
- read is never asserted in LOOKUP, or in SEND without a transfer.
- out_ena is never asserted outside SEND and is at most one-hot.
- drop and a transfer are mutually exclusive in any cycle.
- sent_cnt and drop_cnt saturate at 2^CNT_W-1 and never wrap.
- All registers update on the rising edge of clk.

Test Plan:
- Basic send: after reset, empty=0, item_in=12'hA53, table_data=2, out_busy=0 → read pulse at cycle 0, out_ena=5'b00100 with item_out=12'hA53 at cycle 2, sent_cnt=1, then IDLE.
- Busy stall: dir=1, out_busy[1] held high 5 cycles then low → out_ena=0 for 5 SEND cycles, out_ena[1] in the 6th, stalled stays 0 (TIMEOUT=16), sent_cnt=1.
- Back-to-back: FIFO holds 4 flits, all outputs free → read pulses at cycles 0,2,4,6; out_ena pulses at 2,4,6,8; sent_cnt=4.
- Invalid direction: table_data=7 with NUM_DIRS=5 → drop pulse in the LOOKUP cycle, drop_cnt=1, no out_ena; the next flit is popped on the following cycle.
- Timeout: out_busy[3] held high, TIMEOUT=4:
  - DROP_ON_TIMEOUT=1 → stalled and drop high in the 4th SEND cycle, drop_cnt=1, return to IDLE.
  - DROP_ON_TIMEOUT=0 → stalled stays high until busy drops, then the flit is delivered.
- Reset mid-SEND with out_busy high: rst_n low → out_ena=0, read=0, counters=0 immediately (asynchronous); after release, IDLE with no stale transfer.
